// File: rtl/shift_sub_divider_pkg.sv
// Shared board definitions for the shift-add multiplier and shift-subtract divider:
// FSM state encoding and the {remainder, quotient} LED packing.
package shift_sub_divider_pkg;

    // Widest operand the packing helper carries; operand widths above this are unsupported.
    localparam int MAX_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

    // Places rem directly above the n-bit quo; callers cast the result to 2n bits.
    function automatic logic [2*MAX_W-1:0] pack_result(
        input logic [MAX_W-1:0] rem,
        input logic [MAX_W-1:0] quo,
        input int unsigned      n
    );
        return ({{MAX_W{1'b0}}, rem} << n) | {{MAX_W{1'b0}}, quo};
    endfunction

endpackage

// File: rtl/shift_sub_divider_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and shift the outcome into the quotient.
module shift_sub_divider_div_step #(
    parameter int N = 8
) (
    input  logic [N-1:0] i_rem,
    input  logic [N-1:0] i_quo,
    input  logic [N-1:0] i_div,
    output logic [N-1:0] o_rem,
    output logic [N-1:0] o_quo
);

    logic [N:0] w_trial;

    always_comb begin
        // NOTE: every output gets a default first, so no path through the block can infer a latch.
        w_trial = {i_rem, i_quo[N-1]};
        o_rem   = w_trial[N-1:0];
        o_quo   = {i_quo[N-2:0], 1'b0};
        if (w_trial >= {1'b0, i_div}) begin
            // The difference is below the divisor, so N bits hold it exactly.
            o_rem = w_trial[N-1:0] - i_div;
            o_quo = {i_quo[N-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/shift_sub_divider.sv
// Sequential restoring divider for the lab board: operands from the switches, the last
// complete {remainder, quotient} on the LEDs, recomputed whenever the switches change.
module shift_sub_divider
    import shift_sub_divider_pkg::*;
#(
    parameter int N   = 8,
    parameter bit INV = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [2*N-1:0] sw,
    output logic [2*N-1:0] led,
    output logic         busy
);

    localparam int CNT_W = $clog2(N);
    localparam int LED_W = 2 * N;

    logic [LED_W-1:0] r_sw_q;
    logic             r_chg;
    state_t           r_state;
    state_t           w_state_next;
    logic [N-1:0]     r_quo;
    logic [N-1:0]     r_div;
    // The partial remainder never reaches the divisor, so its top bit is always zero and is not stored.
    logic [N-1:0]     r_rem;
    logic [CNT_W-1:0] r_cnt;
    logic [LED_W-1:0] r_res;
    logic [N-1:0]     w_rem_next;
    logic [N-1:0]     w_quo_next;
    logic [LED_W-1:0] w_res;

    shift_sub_divider_div_step #(.N(N)) u_div_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_div (r_div),
        .o_rem (w_rem_next),
        .o_quo (w_quo_next)
    );

    // A zero divisor skips CALC, so r_quo still holds the dividend when DONE packs it.
    assign w_res = (r_div == '0)
                 ? LED_W'(pack_result(MAX_W'(r_quo), MAX_W'({N{1'b1}}), N))
                 : LED_W'(pack_result(MAX_W'(r_rem), MAX_W'(r_quo), N));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: w_state_next = IDLE;
            LOAD: w_state_next = (r_sw_q[2*N-1:N] == '0) ? DONE : CALC;
            CALC: if (r_cnt == CNT_W'(N - 1)) w_state_next = DONE;
            DONE: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        // A switch change restarts from any state; DONE still commits its result first.
        if (r_chg) w_state_next = LOAD;
    end

    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sw_q  <= '0;
            r_chg   <= 1'b0;
            r_state <= IDLE;
            r_quo   <= '0;
            r_div   <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_res   <= '0;
        end else begin
            r_sw_q  <= sw;
            r_chg   <= (sw != r_sw_q);
            r_state <= w_state_next;
            case (r_state)
                LOAD: begin
                    r_quo <= r_sw_q[N-1:0];
                    r_div <= r_sw_q[2*N-1:N];
                    r_rem <= '0;
                    r_cnt <= '0;
                end
                CALC: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                DONE:    r_res <= w_res;
                default: ;
            endcase
        end
    end

    assign led  = INV ? ~r_res : r_res;
    assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_shift_sub_divider.sv
// Scoreboard bench for shift_sub_divider: stimulus queues expected LED values, monitors
// pop and compare them each time busy falls.
module tb_shift_sub_divider;

    localparam int N = 8;
    localparam int W = 2 * N;

    typedef struct {
        logic [W-1:0] led;
        bit           dz;
        bit           restart;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] sw;
    logic [W-1:0] led;
    logic         busy;
    logic [W-1:0] sw_i;
    logic [W-1:0] led_i;
    logic         busy_i;

    exp_t         exp_q[$];
    logic [W-1:0] exp_qi[$];
    exp_t         mon_e;

    int checks   = 0;
    int failures = 0;
    int edge_cnt = 0;
    int t_stim   = 0;
    int busy_len = 0;
    bit prev_busy   = 1'b0;
    bit prev_busy_i = 1'b0;
    bit watch_en    = 1'b0;
    bit saw_partial = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    shift_sub_divider #(.N(N), .INV(1'b0)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (sw),
        .led   (led),
        .busy  (busy)
    );

    shift_sub_divider #(.N(N), .INV(1'b1)) u_dut_inv (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (sw_i),
        .led   (led_i),
        .busy  (busy_i)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d..%0d", name, act, lo, hi);
        end
    endtask

    // Result monitor for the non-inverted board: a falling busy means a fresh result.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_len  = 0;
            prev_busy = 1'b0;
        end else begin
            if (busy) busy_len++;
            if (prev_busy && !busy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_result actual=0x%0h expected=none", led);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("result", led, mon_e.led);
                    if (mon_e.dz) begin
                        check("dz_latency", edge_cnt - t_stim, 4);
                        check("dz_busy_cycles", busy_len, 2);
                    end else begin
                        check_range("latency", edge_cnt - t_stim, N + 3, N + 4);
                        if (!mon_e.restart) check_range("busy_cycles", busy_len, N + 1, N + 2);
                    end
                end
                busy_len = 0;
            end
            prev_busy = busy;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_busy_i = 1'b0;
        end else begin
            if (prev_busy_i && !busy_i) begin
                if (exp_qi.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_inv_result actual=0x%0h expected=none", led_i);
                end else begin
                    check("inv_result", led_i, exp_qi.pop_front());
                end
            end
            prev_busy_i = busy_i;
        end
    end

    always @(negedge clk) begin
        if (watch_en && led == 16'h020E) saw_partial = 1'b1;
    end

    task automatic apply(input logic [W-1:0] v, input logic [W-1:0] exp_led, input bit dz);
        exp_t e;
        @(posedge clk);
        #1;
        sw        = v;
        t_stim    = edge_cnt;
        e.led     = exp_led;
        e.dz      = dz;
        e.restart = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_qi.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size() + exp_qi.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        exp_t e;
        rst_n = 1'b0;
        sw    = '0;
        sw_i  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_led", led, 16'h0000);
        check("reset_busy", busy, 1'b0);
        check("reset_led_inv", led_i, 16'hFFFF);
        check("reset_busy_inv", busy_i, 1'b0);

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("zero_sw_busy", busy, 1'b0);
        check("zero_sw_led", led, 16'h0000);

        // 100 / 7 = 14 r 2 on both boards
        apply({8'd7, 8'd100}, 16'h020E, 1'b0);
        sw_i = {8'd7, 8'd100};
        exp_qi.push_back(16'hFDF1);
        drain("drain_100_div_7");

        apply({8'd1, 8'd255}, 16'h00FF, 1'b0);
        drain("drain_255_div_1");
        apply({8'd10, 8'd3}, 16'h0300, 1'b0);
        drain("drain_3_div_10");
        apply({8'd255, 8'd254}, 16'hFE00, 1'b0);
        drain("drain_254_div_255");
        apply({8'd0, 8'd5}, 16'h05FF, 1'b1);
        drain("drain_div_zero");

        // Restart during the fourth CALC cycle: 200 / 3 = 66 r 2 replaces 100 / 7
        @(posedge clk);
        #1;
        sw       = {8'd7, 8'd100};
        watch_en = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        sw        = {8'd3, 8'd200};
        t_stim    = edge_cnt;
        e.led     = 16'h0242;
        e.dz      = 1'b0;
        e.restart = 1'b1;
        exp_q.push_back(e);
        drain("drain_restart");
        watch_en = 1'b0;
        check("no_abandoned_result", saw_partial, 1'b0);

        // Reset in the middle of 250 / 10, then re-run with the switches unchanged
        @(posedge clk);
        #1;
        sw = {8'd10, 8'd250};
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midcalc_reset_led", led, 16'h0000);
        check("midcalc_reset_busy", busy, 1'b0);
        check("midcalc_reset_led_inv", led_i, 16'hFFFF);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        t_stim    = edge_cnt;
        e.led     = 16'h0019;
        e.dz      = 1'b0;
        e.restart = 1'b0;
        exp_q.push_back(e);
        exp_qi.push_back(16'hFDF1);
        drain("drain_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
